// File: rtl/maxpool_seq.sv
`default_nettype none
// ============================================================================
//  Module   : maxpool_seq
//  Brief    : Streaming 1-D max-pooling stage. Accepts a valid/data sample
//             stream and emits one registered result per POOL_SIZE accepted
//             samples: the signed maximum of that window. Output data is
//             forced to zero whenever o_valid is low.
//  Revision : 1.0 - initial release
// ============================================================================
module maxpool_seq #(
    parameter int DATA_WIDTH = 16,
    parameter int POOL_SIZE  = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_valid,
    input  logic signed [DATA_WIDTH-1:0] i_data_bus,
    input  logic                         i_en,
    input  logic                         i_clear,
    output logic                         o_valid,
    output logic signed [DATA_WIDTH-1:0] o_data_bus,
    output logic                         o_busy
);

    // Window counter width; a single-sample window still gets one bit so the
    // counter logic stays uniform (it simply never leaves zero).
    localparam int CNT_WIDTH = (POOL_SIZE > 1) ? $clog2(POOL_SIZE) : 1;

    localparam logic [CNT_WIDTH-1:0]         c_cnt_zero  = '0;
    localparam logic [CNT_WIDTH-1:0]         c_cnt_one   = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]         c_cnt_last  = CNT_WIDTH'(POOL_SIZE - 1);
    localparam logic signed [DATA_WIDTH-1:0] c_data_zero = '0;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [CNT_WIDTH-1:0]         r_cnt;
    logic signed [DATA_WIDTH-1:0] r_max;
    logic                         r_out_valid;
    logic signed [DATA_WIDTH-1:0] r_out_data;
    logic                         r_busy;

    // ------------------------------------------------------------------------
    // Next-state terms
    // ------------------------------------------------------------------------
    logic                         w_accept;
    logic [CNT_WIDTH-1:0]         w_cnt_base;
    logic signed [DATA_WIDTH-1:0] w_max_base;
    logic                         w_first;
    logic                         w_final;
    logic signed [DATA_WIDTH-1:0] w_cand;
    logic [CNT_WIDTH-1:0]         w_cnt_next;
    logic signed [DATA_WIDTH-1:0] w_max_next;
    logic                         w_out_valid_next;
    logic signed [DATA_WIDTH-1:0] w_out_data_next;

    assign w_accept = i_en & i_valid;

    // Clear discards the partial window before the current sample is
    // considered, so a same-edge accept opens a fresh window. Clear is not
    // gated by i_en.
    assign w_cnt_base = i_clear ? c_cnt_zero  : r_cnt;
    assign w_max_base = i_clear ? c_data_zero : r_max;

    assign w_first = (w_cnt_base == c_cnt_zero);
    assign w_final = (w_cnt_base == c_cnt_last);

    // The first sample of a window seeds the running max outright; later
    // samples take the full-width signed maximum with no width growth.
    assign w_cand = w_first ? i_data_bus
                  : ((i_data_bus > w_max_base) ? i_data_bus : w_max_base);

    // Decide counter, running max and output for the coming edge
    always_comb begin
        w_cnt_next       = w_cnt_base;
        w_max_next       = w_max_base;
        w_out_valid_next = 1'b0;
        w_out_data_next  = c_data_zero;
        if (w_accept) begin
            if (w_final) begin
                // Window complete: publish the max and restart the window.
                w_cnt_next       = c_cnt_zero;
                w_max_next       = c_data_zero;
                w_out_valid_next = 1'b1;
                w_out_data_next  = w_cand;
            end else begin
                w_cnt_next = w_cnt_base + c_cnt_one;
                w_max_next = w_cand;
            end
        end
    end

    // Register window state and the output stage; reset drops any partial window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= c_cnt_zero;
            r_max       <= c_data_zero;
            r_out_valid <= 1'b0;
            r_out_data  <= c_data_zero;
            r_busy      <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_next;
            r_max       <= w_max_next;
            r_out_valid <= w_out_valid_next;
            r_out_data  <= w_out_data_next;
            r_busy      <= (w_cnt_next != c_cnt_zero);
        end
    end

    assign o_valid    = r_out_valid;
    assign o_data_bus = r_out_data;
    assign o_busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_maxpool_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_maxpool_seq
//  Brief    : Bench for maxpool_seq. Two instances (POOL_SIZE 4 and 1) share
//             one input stream; a queue-based window model predicts every
//             output cycle, and directed sequences pin literal results.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_maxpool_seq;

    localparam int DW = 16;

    logic          clk;
    logic          rst_n;
    logic          i_valid;
    logic [DW-1:0] i_data_bus;
    logic          i_en;
    logic          i_clear;

    logic          o_valid4, o_busy4;
    logic [DW-1:0] o_data4;
    logic          o_valid1, o_busy1;
    logic [DW-1:0] o_data1;

    int n_total = 0;
    int n_pass  = 0;

    maxpool_seq #(.DATA_WIDTH(DW), .POOL_SIZE(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_data_bus(i_data_bus),
        .i_en(i_en), .i_clear(i_clear),
        .o_valid(o_valid4), .o_data_bus(o_data4), .o_busy(o_busy4)
    );

    maxpool_seq #(.DATA_WIDTH(DW), .POOL_SIZE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_data_bus(i_data_bus),
        .i_en(i_en), .i_clear(i_clear),
        .o_valid(o_valid1), .o_data_bus(o_data1), .o_busy(o_busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    endtask

    // ------------------------------------------------------------------------
    // Reference model: each window is a queue of accepted samples; when it
    // holds POOL_SIZE entries its maximum is the result for the next cycle.
    // ------------------------------------------------------------------------
    int            q4[$];
    int            q1[$];
    logic          e4_v = 1'b0, e4_b = 1'b0, e1_v = 1'b0, e1_b = 1'b0;
    logic [DW-1:0] e4_d = '0, e1_d = '0;

    function automatic int qmax(input int q[$]);
        int m = q[0];
        foreach (q[k]) if (q[k] > m) m = q[k];
        return m;
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            e4_v = 1'b0; e4_d = '0; e1_v = 1'b0; e1_d = '0;
            if (!rst_n) begin
                q4.delete(); q1.delete();
            end else begin
                if (i_clear) begin q4.delete(); q1.delete(); end
                if (i_en && i_valid) begin
                    q4.push_back(int'($signed(i_data_bus)));
                    q1.push_back(int'($signed(i_data_bus)));
                end
                if (q4.size() == 4) begin e4_v = 1'b1; e4_d = DW'(qmax(q4)); q4.delete(); end
                if (q1.size() == 1) begin e1_v = 1'b1; e1_d = DW'(qmax(q1)); q1.delete(); end
            end
            e4_b = (q4.size() != 0);
            e1_b = (q1.size() != 0);
        end
    end

    // Every-cycle comparison of both instances against the model
    initial begin
        forever begin
            @(negedge clk);
            check("p4_valid", 32'(o_valid4), 32'(e4_v));
            check("p4_data",  32'(o_data4),  32'(e4_d));
            check("p4_busy",  32'(o_busy4),  32'(e4_b));
            check("p1_valid", 32'(o_valid1), 32'(e1_v));
            check("p1_data",  32'(o_data1),  32'(e1_d));
            check("p1_busy",  32'(o_busy1),  32'(e1_b));
        end
    end

    // Called at a negedge: present inputs, return at the next negedge
    task automatic drive(input logic v, input logic [DW-1:0] d, input logic en, input logic clr);
        i_valid = v; i_data_bus = d; i_en = en; i_clear = clr;
        @(negedge clk);
    endtask

    task automatic acc(input logic [DW-1:0] d);
        drive(1'b1, d, 1'b1, 1'b0);
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic expect4(input string name, input logic [DW-1:0] d);
        check({name, "_v"}, 32'(o_valid4), 32'd1);
        check({name, "_d"}, 32'(o_data4), 32'(d));
    endtask

    initial begin
        rst_n = 1'b0; i_valid = 1'b0; i_data_bus = '0; i_en = 1'b0; i_clear = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_valid", 32'(o_valid4), 32'd0);
        check("reset_data",  32'(o_data4),  32'd0);
        check("reset_busy",  32'(o_busy4),  32'd0);
        rst_n = 1'b1;
        idle();

        // Reset mid-window, asserted between edges
        acc(16'd3); acc(16'd7);
        check("mid_busy", 32'(o_busy4), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid1", 32'(o_valid1), 32'd0);
        check("arst_data1",  32'(o_data1),  32'd0);
        check("arst_busy4",  32'(o_busy4),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        acc(16'd1); acc(16'd2); acc(16'd3); acc(16'd4);
        expect4("after_reset", 16'd4);
        idle();

        // Back-to-back windows
        acc(16'd5); acc(-16'sd2); acc(16'd9); acc(16'd1);
        expect4("b2b_first", 16'd9);
        acc(-16'sd8); acc(-16'sd3); acc(-16'sd1); acc(-16'sd7);
        expect4("b2b_second", 16'hFFFF);

        // Gaps and enable
        acc(16'd10);
        check("gap_busy", 32'(o_busy4), 32'd1);
        idle(); idle(); idle();
        acc(16'd20);
        drive(1'b1, 16'd99, 1'b0, 1'b0);
        acc(16'd15);
        check("gap_busy_late", 32'(o_busy4), 32'd1);
        acc(16'd12);
        expect4("gap", 16'd20);
        check("gap_busy_out", 32'(o_busy4), 32'd0);

        // Clear with same-edge accept, then clear alone
        acc(16'd50); acc(16'd60);
        drive(1'b1, -16'sd4, 1'b1, 1'b1);
        acc(-16'sd9); acc(-16'sd5); acc(-16'sd6);
        expect4("clear", 16'hFFFC);
        acc(16'd33);
        drive(1'b0, '0, 1'b0, 1'b1);
        check("clr_alone_busy",  32'(o_busy4),  32'd0);
        check("clr_alone_valid", 32'(o_valid4), 32'd0);

        // Signed extremes
        acc(16'h8000); acc(16'h8000); acc(16'h8000); acc(16'h8000);
        expect4("all_min", 16'h8000);
        acc(16'h7FFF); acc(16'h8000); acc(16'h0000); acc(16'hFFFF);
        expect4("mixed_ext", 16'h7FFF);
        acc(16'h0); acc(16'h0); acc(16'h0); acc(16'h0);
        expect4("all_zero", 16'h0000);

        // Single-sample window instance: registered passthrough
        acc(16'd3);
        check("p1_a_v", 32'(o_valid1), 32'd1); check("p1_a_d", 32'(o_data1), 32'd3);
        acc(-16'sd3);
        check("p1_b_v", 32'(o_valid1), 32'd1); check("p1_b_d", 32'(o_data1), 32'hFFFD);
        acc(16'd0);
        check("p1_c_v", 32'(o_valid1), 32'd1); check("p1_c_d", 32'(o_data1), 32'd0);
        check("p1_busy", 32'(o_busy1), 32'd0);

        // Randomized traffic, biased toward the signed extremes
        for (int n = 0; n < 3000; n++) begin
            logic [DW-1:0] d;
            int sel;
            sel = $urandom_range(0, 9);
            case (sel)
                0:       d = 16'h8000;
                1:       d = 16'h7FFF;
                2:       d = 16'h0000;
                default: d = DW'($urandom);
            endcase
            drive(($urandom_range(0, 9) < 7), d, ($urandom_range(0, 9) < 8),
                  ($urandom_range(0, 19) == 0));
        end
        idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/maxpool_seq.md
Name: maxpool_seq

Overview:
- Streaming 1-D max-pooling stage placed directly downstream of the sequential LeakyReLU activation stage.
- Consumes the activation's valid/data stream and emits one output per POOL_SIZE accepted samples: the signed maximum of that window.
- Output is registered and uses the same valid/data/enable conventions and zero dummy data as the activation stage, so the two chain with no glue logic.

Parameters:
- DATA_WIDTH, 16, width of input/output samples, 2's complement signed.
- POOL_SIZE, 4, number of accepted samples per pooling window; legal range 1..256.
- CNT_WIDTH, derived localparam, max(1, $clog2(POOL_SIZE)), width of the window sample counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  input sample valid.
- i_data_bus  input  DATA_WIDTH  signed input sample (activation output).
- i_en  input  1  stage enable.
- i_clear  input  1  synchronous discard of a partial window.
- o_valid  output  1  one-cycle pulse; pooled result valid.
- o_data_bus  output  DATA_WIDTH  signed pooled maximum; all zeros when o_valid=0.
- o_busy  output  1  high while a partial window is held (sample count 1..POOL_SIZE-1).

Behaviour:
- Reset (rst_n low, async): o_valid=0, o_data_bus=0, o_busy=0, counter=0, running max=0. Takes effect immediately, regardless of clk. A partial window in progress at reset is lost.
- Accept condition: accept = i_en & i_valid, sampled on the rising clk edge.
- Comparison: signed compare of full DATA_WIDTH. No width growth; output format equals input format.
- Window first sample (counter=0, accept): running max <= sample; counter <= 1.
- Window middle sample (0<counter<POOL_SIZE-1, accept): running max <= max(running max, sample); counter++.
- Window final sample (counter=POOL_SIZE-1, accept): next cycle o_data_bus = max(running max, sample) and o_valid=1. Counter <= 0.
- POOL_SIZE=1: every accepted sample is a final sample, giving a 1-cycle registered passthrough.
- Latency: 1 cycle from the edge that accepts a window's final sample to o_valid high.
- Output dummy data: on every cycle without a final-sample accept, o_valid=0 and o_data_bus=0.
- Gaps in i_valid (i_en=1, i_valid=0): counter and running max hold; the window spans the gap.
- i_en=0: counter and running max frozen; o_valid=0, o_data_bus=0.
- i_clear=1: counter and running max are discarded first.
  - If the same edge also has accept, the sample becomes the first sample of a new window: counter=1, max=sample.
  - With POOL_SIZE=1, that sample is output.
  - i_clear is honoured even when i_en=0.
  - i_clear never produces an output for the discarded partial window.
- o_busy: registered; equals (counter != 0) after each edge.
- Extremes: a window of all -32768 (DATA_WIDTH=16) outputs 0x8000. An all-zero window outputs 0 with o_valid=1; o_valid, not data, distinguishes this from dummy zeros.
- No backpressure: the downstream consumer must take each result in its o_valid cycle.

Test Plan:
- Reset mid-window (POOL_SIZE=4): accept 3, 7; assert rst_n low between edges → o_valid=0, o_data_bus=0, o_busy=0 immediately. After release, accept 1, 2, 3, 4 → single output 4.
- Back-to-back windows: continuous valid stream 5, -2, 9, 1, -8, -3, -1, -7 → o_valid pulses 1 cycle after samples 4 and 8, with data 9 then -1; o_data_bus=0 on all other cycles.
- Gaps and enable: stream 10, (valid=0 ×3), 20, (i_en=0 with valid=1, data 99), 15, 12 → single output 20; 99 ignored; o_busy high from after sample 10 until the output cycle.
- Clear: accept 50, 60; i_clear=1 with accept of -4; then accept -9, -5, -6 → output -4 (50 and 60 discarded). Also i_clear alone mid-window → no output, o_busy=0.
- Signed extremes: window 0x8000, 0x8000, 0x8000, 0x8000 → 0x8000. Window 0x7FFF, 0x8000, 0, -1 → 0x7FFF.
- POOL_SIZE=1 build: stream 3, -3, 0 → outputs 3, -3, 0 each one cycle later, o_valid high on all three, o_busy always 0.
